// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: state encoding, step sizes and
// target alignment masks.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_t;

  localparam logic [31:0] STEP_ARM   = 32'd4;
  localparam logic [31:0] STEP_THUMB = 32'd2;
  localparam logic [31:0] MASK_ARM   = 32'hFFFF_FFFC;
  localparam logic [31:0] MASK_THUMB = 32'hFFFF_FFFE;

  function automatic logic [31:0] step_size(input logic thumb);
    return thumb ? STEP_THUMB : STEP_ARM;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic thumb);
    return addr & (thumb ? MASK_THUMB : MASK_ARM);
  endfunction

endpackage

// File: rtl/pc_gen_adder32.sv
// Plain 32-bit ripple-style adder used as the PC incrementer.
module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch stepping, redirect/exception
// steering with a one-entry pending slot during stalls, and fetch history.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int             AW        = 32,
  parameter logic [AW-1:0]  RESET_VEC = {AW{1'b0}},
  parameter int             DEPTH     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                i_thumb,
  input  logic                i_redir_en,
  input  logic [AW-1:0]       i_redir_addr,
  input  logic                i_exc_en,
  input  logic [AW-1:0]       i_exc_addr,
  input  logic                i_ack,
  output logic                o_req,
  output logic [AW-1:0]       o_pc,
  output logic [AW-1:0]       o_pc_next,
  output logic [DEPTH*AW-1:0] o_hist,
  output logic [DEPTH-1:0]    o_hist_vld,
  output logic                o_flush
);

  pc_state_t        r_state;
  logic [AW-1:0]    r_pc;
  logic             r_req;
  logic             r_flush;
  logic [AW-1:0]    r_hist [DEPTH];
  logic [DEPTH-1:0] r_hist_vld;
  logic             r_pend_vld;
  logic             r_pend_exc;
  logic [AW-1:0]    r_pend_addr;

  logic [31:0]      w_sum;
  logic             w_cout;
  logic             w_unused;
  logic [AW-1:0]    w_inc;
  logic [AW-1:0]    w_raw_tgt;
  logic [AW-1:0]    w_tgt;
  logic             w_adv;
  logic             w_jump;
  logic             w_any_req;

  adder32 u_inc (
    .i_a    (32'(r_pc)),
    .i_b    (step_size(i_thumb)),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out and any bits above AW are discarded: the PC wraps silently.
  assign w_unused = ^{w_cout, w_sum};
  assign w_inc    = w_sum[AW-1:0];

  assign w_any_req = i_exc_en | i_redir_en;
  assign w_adv     = en & r_req & i_ack;
  assign w_jump    = en & (w_any_req | r_pend_vld);
  assign w_raw_tgt = i_exc_en   ? i_exc_addr   :
                     i_redir_en ? i_redir_addr : r_pend_addr;
  assign w_tgt     = AW'(align_addr(32'(w_raw_tgt), i_thumb));
  assign o_pc_next = w_jump ? w_tgt : (w_adv ? w_inc : r_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VEC;
      r_req       <= 1'b0;
      r_flush     <= 1'b0;
      r_hist_vld  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_exc  <= 1'b0;
      r_pend_addr <= '0;
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
    end else begin
      r_pc    <= o_pc_next;
      r_flush <= w_jump;
      r_req   <= 1'b1;
      if (en) begin
        r_state    <= ST_RUN;
        r_pend_vld <= 1'b0;
        r_pend_exc <= 1'b0;
        if (w_jump) begin
          r_hist_vld <= '0;
        end else if (w_adv) begin
          r_hist[0]     <= r_pc;
          r_hist_vld[0] <= 1'b1;
          for (int k = 1; k < DEPTH; k++) begin
            r_hist[k]     <= r_hist[k-1];
            r_hist_vld[k] <= r_hist_vld[k-1];
          end
        end
      end else begin
        // A captured exception may only be displaced by a later exception.
        if (i_exc_en) begin
          r_pend_vld  <= 1'b1;
          r_pend_exc  <= 1'b1;
          r_pend_addr <= i_exc_addr;
        end else if (i_redir_en && !(r_pend_vld && r_pend_exc)) begin
          r_pend_vld  <= 1'b1;
          r_pend_exc  <= 1'b0;
          r_pend_addr <= i_redir_addr;
        end
        if (w_any_req || r_pend_vld) r_state <= ST_HOLD;
        else if (r_state == ST_BOOT) r_state <= ST_RUN;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
    assign o_hist[gi*AW +: AW] = r_hist[gi];
  end

  assign o_pc       = r_pc;
  assign o_req      = r_req;
  assign o_flush    = r_flush;
  assign o_hist_vld = r_hist_vld;

endmodule
